// File: rtl/trap_pkg.sv
// Shared types and constants for the trap sequencer.
// No logic here; latency/backpressure are properties of the modules that import it.
package trap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_FETCH,
    ST_REDIRECT,
    ST_RETURN,
    ST_HALT
  } trap_state_t;

  localparam int CAUSE_ILLEGAL  = 0;
  localparam int CAUSE_OVERFLOW = 1;
  localparam int CAUSE_MISALIGN = 2;
  localparam int CAUSE_EXT      = 3;

  localparam longint unsigned TRAP_VEC_BASE = 64'd254;

endpackage

// File: rtl/trap_prio_enc.sv
// Lowest-index-first priority encoder over the trap request lines.
// Latency: combinational; no backpressure, vld simply mirrors |req.
module trap_prio_enc #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          vld
);

  always_comb begin
    idx = '0;
    vld = |req;
    // Walk downwards so the lowest set index is the last to write idx.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// Trap sequencer: captures cause/EPC, fetches the handler vector, redirects PC, handles return.
// Latency: pc_load 3 edges after acceptance plus memory waits; stalls on mem_ready, halts after TIMEOUT FETCH cycles.
module trap_sequencer
  import trap_pkg::*;
#(
  parameter int              XLEN      = 64,
  parameter int              N_CAUSES  = 4,
  parameter logic [XLEN-1:0] VEC_BASE  = XLEN'(TRAP_VEC_BASE),
  parameter int              VEC_BYTES = 1,
  parameter int              TIMEOUT   = 15
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ctrl_idle,
  input  logic [N_CAUSES-1:0]         trap_req,
  input  logic                        trap_ret,
  input  logic [XLEN-1:0]             pc_in,
  input  logic [XLEN-1:0]             mem_rdata,
  input  logic                        mem_ready,
  output logic                        mem_req,
  output logic [XLEN-1:0]             mem_addr,
  output logic                        pc_load,
  output logic [XLEN-1:0]             pc_target,
  output logic                        trap_active,
  output logic                        in_handler,
  output logic [$clog2(N_CAUSES)-1:0] cause,
  output logic [XLEN-1:0]             epc,
  output logic                        double_fault
);

  localparam int CW    = $clog2(N_CAUSES);
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam int VBITS = (VEC_BYTES * 8 < XLEN) ? VEC_BYTES * 8 : XLEN;
  localparam logic [XLEN-1:0] VEC_MASK = {XLEN{1'b1}} >> (XLEN - VBITS);

  trap_state_t     stateQ, stateNext;
  logic [CW-1:0]   causeQ;
  logic [XLEN-1:0] epcQ;
  logic [XLEN-1:0] memAddrQ;
  logic [XLEN-1:0] vectorQ;
  logic [TW-1:0]   waitCnt;
  logic            inHandlerQ;
  logic [CW-1:0]   encIdx;
  logic            encVld;
  logic            latchTrap;

  trap_prio_enc #(
    .N  (N_CAUSES),
    .IW (CW)
  ) u_prio (
    .req (trap_req),
    .idx (encIdx),
    .vld (encVld)
  );

  always_comb begin
    stateNext = stateQ;
    latchTrap = 1'b0;
    case (stateQ)
      ST_IDLE: begin
        // A new trap outranks a return; inside a handler it is fatal.
        if (ctrl_idle && encVld) begin
          if (!inHandlerQ) begin
            stateNext = ST_CAPTURE;
            latchTrap = 1'b1;
          end else begin
            stateNext = ST_HALT;
          end
        end else if (trap_ret && inHandlerQ) begin
          stateNext = ST_RETURN;
        end
      end
      ST_CAPTURE:  stateNext = ST_FETCH;
      ST_FETCH: begin
        // The TIMEOUT-th FETCH cycle still accepts mem_ready.
        if (mem_ready) begin
          stateNext = ST_REDIRECT;
        end else if (waitCnt == TW'(TIMEOUT - 1)) begin
          stateNext = ST_HALT;
        end
      end
      ST_REDIRECT: stateNext = ST_IDLE;
      ST_RETURN:   stateNext = ST_IDLE;
      ST_HALT:     stateNext = ST_HALT;
      default:     stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ     <= ST_IDLE;
      causeQ     <= '0;
      epcQ       <= '0;
      memAddrQ   <= '0;
      vectorQ    <= '0;
      waitCnt    <= '0;
      inHandlerQ <= 1'b0;
    end else begin
      stateQ <= stateNext;
      case (stateQ)
        ST_IDLE: begin
          if (latchTrap) begin
            causeQ <= encIdx;
            epcQ   <= pc_in;
          end
        end
        ST_CAPTURE: begin
          memAddrQ <= VEC_BASE + XLEN'(causeQ) * XLEN'(VEC_BYTES);
          waitCnt  <= '0;
        end
        ST_FETCH: begin
          if (mem_ready) begin
            vectorQ <= mem_rdata & VEC_MASK;
          end else begin
            waitCnt <= waitCnt + TW'(1);
          end
        end
        ST_REDIRECT: inHandlerQ <= 1'b1;
        ST_RETURN:   inHandlerQ <= 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    pc_target = '0;
    case (stateQ)
      ST_REDIRECT: pc_target = vectorQ;
      ST_RETURN:   pc_target = epcQ;
      default:     pc_target = '0;
    endcase
  end

  assign trap_active  = (stateQ != ST_IDLE);
  assign mem_req      = (stateQ == ST_FETCH);
  assign pc_load      = (stateQ == ST_REDIRECT) || (stateQ == ST_RETURN);
  assign double_fault = (stateQ == ST_HALT);
  assign mem_addr     = memAddrQ;
  assign in_handler   = inHandlerQ;
  assign cause        = causeQ;
  assign epc          = epcQ;

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: default configuration plus a 16-cause, 8-byte-vector instance.
module tb_trap_sequencer;
  import trap_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // Default-parameter instance
  logic        ctrlIdle, trapRet, memReady;
  logic [3:0]  trapReq;
  logic [63:0] pcIn, memRdata;
  logic        memReq, pcLoad, trapActive, inHandler, doubleFault;
  logic [63:0] memAddr, pcTarget, epc;
  logic [1:0]  cause;

  // Wide-configuration instance
  logic        ctrlIdleB, trapRetB, memReadyB;
  logic [15:0] trapReqB;
  logic [63:0] pcInB, memRdataB;
  logic        memReqB, pcLoadB, trapActiveB, inHandlerB, doubleFaultB;
  logic [63:0] memAddrB, pcTargetB, epcB;
  logic [3:0]  causeB;

  trap_sequencer u_dut (
    .clk(clk), .reset(reset), .ctrl_idle(ctrlIdle), .trap_req(trapReq),
    .trap_ret(trapRet), .pc_in(pcIn), .mem_rdata(memRdata), .mem_ready(memReady),
    .mem_req(memReq), .mem_addr(memAddr), .pc_load(pcLoad), .pc_target(pcTarget),
    .trap_active(trapActive), .in_handler(inHandler), .cause(cause), .epc(epc),
    .double_fault(doubleFault)
  );

  trap_sequencer #(
    .XLEN(64), .N_CAUSES(16), .VEC_BASE(64'h1000), .VEC_BYTES(8), .TIMEOUT(15)
  ) u_dut16 (
    .clk(clk), .reset(reset), .ctrl_idle(ctrlIdleB), .trap_req(trapReqB),
    .trap_ret(trapRetB), .pc_in(pcInB), .mem_rdata(memRdataB), .mem_ready(memReadyB),
    .mem_req(memReqB), .mem_addr(memAddrB), .pc_load(pcLoadB), .pc_target(pcTargetB),
    .trap_active(trapActiveB), .in_handler(inHandlerB), .cause(causeB), .epc(epcB),
    .double_fault(doubleFaultB)
  );

  typedef struct {
    logic [3:0]  req;
    logic [63:0] pc;
    logic [63:0] rdata;
    int          waitCyc;
    logic [63:0] expCause;
    logic [63:0] expAddr;
    logic [63:0] expTarget;
  } vec_t;

  vec_t vecs[4];
  int nChecks = 0;
  int nPass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkZero(input string tag);
    chk({tag, "_trap_active"}, trapActive, 0);
    chk({tag, "_mem_req"}, memReq, 0);
    chk({tag, "_pc_load"}, pcLoad, 0);
    chk({tag, "_pc_target"}, pcTarget, 0);
    chk({tag, "_mem_addr"}, memAddr, 0);
    chk({tag, "_cause"}, cause, 0);
    chk({tag, "_epc"}, epc, 0);
    chk({tag, "_in_handler"}, inHandler, 0);
    chk({tag, "_double_fault"}, doubleFault, 0);
  endtask

  task automatic clearInputs();
    ctrlIdle = 0; trapReq = '0; trapRet = 0; pcIn = '0; memRdata = '0; memReady = 0;
  endtask

  task automatic doReset(input string tag);
    #2 reset = 1'b0;
    #1 checkZero(tag);
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic takeTrap(input vec_t v, input string tag);
    int reqCycles;
    logic addrStable;
    ctrlIdle = 1; trapReq = v.req; pcIn = v.pc;
    tick();
    ctrlIdle = 0; trapReq = '0; pcIn = 64'hBAD0;
    chk({tag, "_capture_active"}, trapActive, 1);
    chk({tag, "_capture_no_load"}, pcLoad, 0);
    chk({tag, "_cause"}, cause, v.expCause);
    chk({tag, "_epc"}, epc, v.pc);
    tick();
    chk({tag, "_fetch_no_load"}, pcLoad, 0);
    chk({tag, "_mem_addr"}, memAddr, v.expAddr);
    reqCycles  = int'(memReq);
    addrStable = 1'b1;
    for (int k = 0; k < v.waitCyc; k++) begin
      memRdata = 64'h5555_5555_5555_5555;
      tick();
      reqCycles += int'(memReq);
      if (memAddr !== v.expAddr) addrStable = 1'b0;
    end
    chk({tag, "_mem_req_cycles"}, 64'(reqCycles), 64'(v.waitCyc + 1));
    chk({tag, "_addr_stable"}, addrStable, 1);
    memReady = 1; memRdata = v.rdata;
    tick();
    memReady = 0; memRdata = '0;
    chk({tag, "_redirect_load"}, pcLoad, 1);
    chk({tag, "_redirect_target"}, pcTarget, v.expTarget);
    chk({tag, "_redirect_no_req"}, memReq, 0);
    tick();
    chk({tag, "_in_handler"}, inHandler, 1);
    chk({tag, "_idle_again"}, trapActive, 0);
  endtask

  task automatic doReturn(input logic [63:0] expEpc, input string tag);
    trapRet = 1;
    tick();
    trapRet = 0;
    chk({tag, "_ret_load"}, pcLoad, 1);
    chk({tag, "_ret_target"}, pcTarget, expEpc);
    tick();
    chk({tag, "_ret_in_handler"}, inHandler, 0);
    chk({tag, "_ret_no_load"}, pcLoad, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic sawActive;
    vecs[0] = '{4'b0001, 64'h100, 64'h40, 0, 64'(CAUSE_ILLEGAL), 64'd254, 64'h40};
    vecs[1] = '{4'b1010, 64'h204, 64'hFFFF_FFFF_FFFF_FF88, 0, 64'(CAUSE_OVERFLOW), 64'd255, 64'h88};
    vecs[2] = '{4'b1100, 64'h300, 64'h3312, 5, 64'(CAUSE_MISALIGN), 64'd256, 64'h12};
    vecs[3] = '{4'b1000, 64'hFFFF_FFFF_FFFF_FFFC, 64'hAB7F, 14, 64'(CAUSE_EXT), 64'd257, 64'h7F};

    reset = 0;
    clearInputs();
    ctrlIdleB = 0; trapReqB = '0; trapRetB = 0; pcInB = '0; memRdataB = '0; memReadyB = 0;
    #3 checkZero("reset");
    @(posedge clk);
    #1 reset = 1;
    tick();

    for (int i = 0; i < 4; i++) begin
      takeTrap(vecs[i], $sformatf("vec%0d", i));
      doReturn(vecs[i].pc, $sformatf("vec%0d", i));
    end

    // Requests outside an instruction boundary and stray returns are ignored.
    sawActive = 0;
    ctrlIdle = 0; trapReq = 4'b0001; pcIn = 64'h999;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (trapActive) sawActive = 1;
    end
    trapReq = '0;
    chk("gated_no_active", sawActive, 0);
    chk("gated_epc_kept", epc, 64'hFFFF_FFFF_FFFF_FFFC);
    trapRet = 1;
    tick();
    trapRet = 0;
    chk("stray_ret_no_load", pcLoad, 0);
    chk("stray_ret_idle", trapActive, 0);

    // Vector fetch that never completes.
    ctrlIdle = 1; trapReq = 4'b0100; pcIn = 64'h500;
    tick();
    clearInputs();
    tick();
    repeat (14) tick();
    chk("timeout_last_wait_req", memReq, 1);
    chk("timeout_not_yet", doubleFault, 0);
    tick();
    chk("timeout_double_fault", doubleFault, 1);
    chk("timeout_no_req", memReq, 0);
    chk("timeout_active", trapActive, 1);
    memReady = 1; trapRet = 1; ctrlIdle = 1; trapReq = 4'b0001; pcIn = 64'h777;
    repeat (4) tick();
    chk("halt_sticky", doubleFault, 1);
    chk("halt_cause_frozen", cause, 2);
    chk("halt_epc_frozen", epc, 64'h500);
    chk("halt_no_load", pcLoad, 0);
    clearInputs();
    doReset("timeout_reset");

    // Nested trap inside a handler.
    takeTrap(vecs[0], "nest");
    ctrlIdle = 1; trapReq = 4'b0010; pcIn = 64'h888;
    tick();
    clearInputs();
    chk("nest_double_fault", doubleFault, 1);
    chk("nest_cause_frozen", cause, 0);
    chk("nest_epc_frozen", epc, 64'h100);
    doReset("nest_reset");

    // Nested trap coinciding with a return: the trap wins.
    takeTrap(vecs[1], "nestret");
    ctrlIdle = 1; trapReq = 4'b0001; trapRet = 1;
    tick();
    clearInputs();
    chk("nestret_double_fault", doubleFault, 1);
    chk("nestret_no_load", pcLoad, 0);
    tick();
    chk("nestret_sticky", doubleFault, 1);
    doReset("nestret_reset");

    // Asynchronous reset while a fetch is outstanding.
    ctrlIdle = 1; trapReq = 4'b1000; pcIn = 64'h1234;
    tick();
    clearInputs();
    tick();
    chk("midfetch_req", memReq, 1);
    doReset("midfetch_reset");
    takeTrap(vecs[0], "recover");
    doReturn(vecs[0].pc, "recover");

    // Wide configuration: 16 causes, 8-byte vectors at 0x1000.
    ctrlIdleB = 1; trapReqB = 16'h8200; pcInB = 64'hABC;
    tick();
    ctrlIdleB = 0; trapReqB = '0;
    chk("wide_cause", causeB, 9);
    chk("wide_epc", epcB, 64'hABC);
    tick();
    chk("wide_req", memReqB, 1);
    chk("wide_addr", memAddrB, 64'h1048);
    memReadyB = 1; memRdataB = 64'hDEAD_BEEF_CAFE_F00D;
    tick();
    memReadyB = 0;
    chk("wide_load", pcLoadB, 1);
    chk("wide_target", pcTargetB, 64'hDEAD_BEEF_CAFE_F00D);
    tick();
    chk("wide_in_handler", inHandlerB, 1);
    chk("wide_no_fault", doubleFaultB, 0);
    chk("wide_trap_active", trapActiveB, 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
